scan_index_seq: RTL and testbench
=================================

Name: scan_index_seq

Overview:
- Upstream sequencer that generates the 2-bit select index consumed by the 2-to-4 select decoder stage.
- Auto mode: steps the index 0→1→2→3→0 with a programmable dwell, for LED/digit/keypad scanning.
- Manual mode: loads a requested index through a req/ack handshake.
- Emits index_vld, a per-step tick and a wrap pulse so downstream stages can latch data coherently.

Parameters:
- TICK_DIV, 50000, clock cycles per index dwell in auto mode; legal range 1..65535.
- CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  sequencer enable.
- mode  in  1  0 = auto scan, 1 = manual select.
- man_idx  in  2  requested index in manual mode.
- man_req  in  1  manual load request, level.
- man_ack  out  1  one-cycle acknowledge of man_req.
- index  out  2  current select index, to the decoder.
- index_vld  out  1  index is being actively driven (state ≠ IDLE).
- tick  out  1  one-cycle pulse, coincident with every index change.
- wrap  out  1  one-cycle pulse, coincident with an auto step 3→0.

Behaviour:
- Reset (rst_n=0 at an edge) forces these values, whatever the state:
  - state=IDLE, prescaler=0, req_armed=1.
  - index=0, index_vld=0, man_ack=0, tick=0, wrap=0.
- All outputs are registered. tick, wrap and man_ack are never high for more than one cycle per event.
- State transitions, evaluated each edge; en=0 has priority:
  - any state, en=0 → IDLE. index holds its value, index_vld=0, prescaler=0.
  - IDLE, en=1, mode=0 → SCAN. index loads 0, index_vld=1, prescaler=0, no tick.
  - IDLE, en=1, mode=1 → MANUAL. index holds its value, index_vld=1.
  - SCAN, mode=1 → MANUAL. index holds, prescaler cleared.
  - MANUAL, mode=0 → SCAN. Resumes from the current index, prescaler cleared; the first step comes TICK_DIV cycles later.
- SCAN stepping:
  - prescaler counts 0..TICK_DIV-1.
  - When prescaler = TICK_DIV-1: prescaler→0, index→(index+1) mod 4, tick=1.
  - wrap=1 only on the 3→0 step.
  - TICK_DIV=1 steps every cycle, with tick held high continuously.
  - Index arithmetic is 2-bit unsigned with natural wrap.
- MANUAL handshake:
  - If man_req=1 and req_armed=1 at an edge: index←man_idx, man_ack=1 for one cycle, tick=1, req_armed←0.
  - tick pulses even when man_idx equals the current index; wrap is never asserted in MANUAL.
  - req_armed returns to 1 only after man_req is sampled low. A held req therefore gives exactly one ack.
  - man_req is ignored in IDLE and SCAN; no ack, and req_armed is unchanged.
  - A req arriving on the same edge as a SCAN→MANUAL switch is not served; it is served on the next edge if still high and armed.
- Simultaneous events:
  - en=0 together with a step or a req: IDLE wins, with no tick and no ack.
  - A mode change on the same edge as a prescaler terminal count: the mode change wins and no step occurs.
- Reset mid-operation: rst_n is synchronous and overrides everything on that edge. No pulse outputs are asserted on that edge or the edge after.

Decomposition:
- Shared package scan_pkg:
  - state enum {IDLE, SCAN, MANUAL}.
  - IDX_W=2 and N_SEL=4, shared with the downstream decoder.
- One natural sub-module, tick_prescaler (TICK_DIV, CNT_W).
  - Inputs: clk, rst_n, clr, run.
  - Output: terminal-count pulse.
- The FSM, index register and handshake logic stay in the top module.

Test Plan (bench TICK_DIV=4):
- Reset/enable: hold rst_n=0 for 3 cycles, then release with en=0.
  - All outputs stay 0.
  - Raising en with mode=0 gives index_vld=1 and index=0 on the next edge.
- Auto scan: en=1, mode=0 for 20 cycles.
  - index steps 0,1,2,3,0 every 4 cycles, with tick on each step.
  - wrap fires only on the 3→0 step, i.e. at cycle 16 after entry.
- Manual handshake: mode=1, man_idx=2, man_req held high for 5 cycles.
  - Exactly one man_ack and one tick, and index=2.
  - Drop req for 1 cycle, then re-assert with man_idx=1: a second ack, and index=1.
- Mode switch: in SCAN at index=1 with prescaler=2, set mode=1.
  - index holds at 1 and no tick occurs.
  - Return to mode=0: the next step (1→2) comes 4 cycles later.
- Priority: on the edge where the prescaler hits terminal count, drop en.
  - No tick, index_vld=0, index holds.
  - Separately, assert rst_n=0 mid-scan at index=3: the next edge shows index=0 and no wrap.
- Degenerate divider: re-run with TICK_DIV=1.
  - index increments every cycle and tick stays continuously high.
  - wrap pulses every 4th cycle.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared types and widths for the scan index sequencer and its downstream decoder
package scan_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, MANUAL} state_t;
  localparam int IDX_W = 2;
  localparam int N_SEL = 4;
endpackage

// File: rtl/scan_index_seq_tick_prescaler.sv
// tick_prescaler: dwell counter; tc is high in the last cycle of each TICK_DIV-cycle dwell
module tick_prescaler #(
  parameter int TICK_DIV = 50000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  assign tc = run && cnt == CNT_W'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (run) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/scan_index_seq.sv
// scan_index_seq: 2-bit select index sequencer with timed auto scan and req/ack manual load
module scan_index_seq
  import scan_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [IDX_W-1:0] man_idx,
  input  logic             man_req,
  output logic             man_ack,
  output logic [IDX_W-1:0] index,
  output logic             index_vld,
  output logic             tick,
  output logic             wrap
);
  state_t state, state_nx;
  logic req_armed, armed_nx, tc, clr, serve, tick_nx, wrap_nx;
  logic [IDX_W-1:0] index_nx;
  // Prescaler only runs while staying in SCAN, so mode/en changes swallow a coincident terminal count
  assign clr = !(state == SCAN && en && !mode);
  assign serve = state == MANUAL && en && mode && man_req && req_armed;
  tick_prescaler #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_pre (
    .clk(clk), .rst_n(rst_n), .clr(clr), .run(!clr), .tc(tc)
  );
  always_comb begin
    state_nx = !en ? IDLE : mode ? MANUAL : SCAN;
    index_nx = (state == IDLE && state_nx == SCAN) ? '0 : serve ? man_idx : tc ? index + 1'b1 : index;
    tick_nx = serve || tc;
    wrap_nx = tc && index == IDX_W'(N_SEL - 1);
    armed_nx = serve ? 1'b0 : (state == MANUAL && !man_req) ? 1'b1 : req_armed;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      req_armed <= 1'b1;
      index <= '0;
      index_vld <= 1'b0;
      man_ack <= 1'b0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_nx;
      req_armed <= armed_nx;
      index <= index_nx;
      index_vld <= state_nx != IDLE;
      man_ack <= serve;
      tick <= tick_nx;
      wrap <= wrap_nx;
    end
endmodule

// File: tb/tb_scan_index_seq.sv
// tb_scan_index_seq: directed plan plus random stimulus checked against a behavioural model (TICK_DIV 4 and 1)
module tb_scan_index_seq;
  logic clk = 0, rst_n = 0, en = 0, mode = 0, man_req = 0;
  logic [1:0] man_idx = 0;
  logic [1:0] i4, i1;
  logic v4, t4, w4, a4, v1, t1, w1, a1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  scan_index_seq #(.TICK_DIV(4), .CNT_W(3)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .man_idx(man_idx), .man_req(man_req),
    .man_ack(a4), .index(i4), .index_vld(v4), .tick(t4), .wrap(w4)
  );
  scan_index_seq #(.TICK_DIV(1), .CNT_W(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .man_idx(man_idx), .man_req(man_req),
    .man_ack(a1), .index(i1), .index_vld(v1), .tick(t1), .wrap(w1)
  );

  // mode: 0 idle, 1 scanning, 2 manual; dwell counts cycles spent in the current dwell
  typedef struct {int md; int dwell; int idx; bit armed; bit vld, tick, wrap, ack;} m_t;
  m_t m4, m1;

  function automatic m_t nxt(m_t m, int d, bit rn, bit e, bit md, int mi, bit mr);
    m_t n = m;
    n.tick = 0; n.wrap = 0; n.ack = 0;
    if (!rn) begin
      n.md = 0; n.dwell = 0; n.idx = 0; n.armed = 1; n.vld = 0;
      return n;
    end
    if (!e) begin n.md = 0; n.dwell = 0; end
    else if (m.md == 0) begin n.md = md ? 2 : 1; n.dwell = 0; if (!md) n.idx = 0; end
    else if (m.md == 1) begin
      if (md) begin n.md = 2; n.dwell = 0; end
      else if (m.dwell + 1 == d) begin
        n.dwell = 0; n.idx = (m.idx + 1) % 4; n.tick = 1; n.wrap = (m.idx == 3);
      end else n.dwell = m.dwell + 1;
    end else begin
      if (!md) begin n.md = 1; n.dwell = 0; end
      else if (mr && m.armed) begin n.idx = mi; n.ack = 1; n.tick = 1; n.armed = 0; end
    end
    if (m.md == 2 && !mr) n.armed = 1;
    n.vld = n.md != 0;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input m_t m, input int idx, input bit v, t, w, a);
    chk({tag, ".index"}, idx, m.idx);
    chk({tag, ".index_vld"}, v, m.vld);
    chk({tag, ".tick"}, t, m.tick);
    chk({tag, ".wrap"}, w, m.wrap);
    chk({tag, ".man_ack"}, a, m.ack);
  endtask

  always @(posedge clk) begin
    m4 = nxt(m4, 4, rst_n, en, mode, man_idx, man_req);
    m1 = nxt(m1, 1, rst_n, en, mode, man_idx, man_req);
    #1;
    cmp("m4", m4, i4, v4, t4, w4, a4);
    cmp("m1", m1, i1, v1, t1, w1, a1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic all_zero(input string name);
    chk({name, ".outs4"}, {i4, v4, t4, w4, a4}, 0);
    chk({name, ".outs1"}, {i1, v1, t1, w1, a1}, 0);
  endtask

  initial begin
    int acks, ticks;
    repeat (3) cyc();
    all_zero("reset");
    rst_n = 1;
    repeat (2) cyc();
    all_zero("idle_en0");
    en = 1;
    cyc();
    chk("entry.vld", v4, 1);
    chk("entry.index", i4, 0);
    chk("entry.tick", t4, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("scan.tick", t4, (k % 4 == 0) ? 1 : 0);
      chk("scan.wrap", w4, (k == 16) ? 1 : 0);
      chk("scan.index", i4, (k / 4) % 4);
    end
    mode = 1; man_idx = 2; man_req = 1;
    acks = 0; ticks = 0;
    repeat (5) begin cyc(); acks += a4; ticks += t4; end
    chk("man.acks", acks, 1);
    chk("man.ticks", ticks, 1);
    chk("man.index", i4, 2);
    man_req = 0;
    cyc();
    man_req = 1; man_idx = 1;
    cyc();
    chk("man2.ack", a4, 1);
    chk("man2.index", i4, 1);
    man_req = 0;
    mode = 0;
    repeat (3) cyc();
    mode = 1;
    cyc();
    chk("sw.index", i4, 1);
    chk("sw.tick", t4, 0);
    mode = 0;
    cyc();
    repeat (3) begin cyc(); chk("resume.notick", t4, 0); end
    cyc();
    chk("resume.tick", t4, 1);
    chk("resume.index", i4, 2);
    repeat (3) cyc();
    en = 0;
    cyc();
    chk("pri.tick", t4, 0);
    chk("pri.vld", v4, 0);
    chk("pri.index", i4, 2);
    en = 1;
    cyc();
    repeat (12) cyc();
    chk("pre_rst.index", i4, 3);
    rst_n = 0;
    cyc();
    chk("rst.index", i4, 0);
    chk("rst.wrap", w4, 0);
    chk("rst.tick", t4, 0);
    rst_n = 1;
    cyc();
    chk("post_rst.pulses", {t4, w4, a4, t1, w1, a1}, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("div1.tick", t1, 1);
      chk("div1.index", i1, k % 4);
      chk("div1.wrap", w1, (k % 4 == 0) ? 1 : 0);
    end
    for (int n = 0; n < 3000; n++) begin
      rst_n = $urandom_range(0, 59) != 0;
      en = $urandom_range(0, 24) != 0;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      man_req = $urandom_range(0, 2) != 0;
      man_idx = 2'($urandom_range(0, 3));
      cyc();
    end
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
